// File: rtl/maxnet_pkg.sv
// Shared types and default parameters for the four-lane maxnet
// controller and its datapath top.
package maxnet_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_WAIT,
        S_UPDATE,
        S_DONE
    } ctrl_state_t;

    localparam int PU_LAT_DEF   = 2;
    localparam int ITER_W_DEF   = 8;
    localparam int MAX_ITER_DEF = 255;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter with zero flag; times the PU pipeline
// latency while the controller sits in WAIT.
module lat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/maxnet_ctrl.sv
// Sequencer for the maxnet datapath: load, wait out PU latency,
// write back, until zer or the iteration limit, then hold done.
module maxnet_ctrl
    import maxnet_pkg::*;
#(
    parameter int PU_LAT   = PU_LAT_DEF,
    parameter int ITER_W   = ITER_W_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              ack,
    input  logic              zer,
    output logic              wen,
    output logic              wene,
    output logic              sel,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count
);

    localparam int LW     = cnt_width(PU_LAT);
    localparam int LAT_M1 = (PU_LAT > 0) ? PU_LAT - 1 : 0;
    localparam logic [LW-1:0]     LAT_INIT = LW'(LAT_M1);
    localparam logic [ITER_W-1:0] ITER_LIM = ITER_W'(MAX_ITER);

    ctrl_state_t       r_state;
    ctrl_state_t       w_next;
    logic [ITER_W-1:0] r_iter;
    logic              r_timeout;
    logic              w_lat_load;
    logic              w_lat_en;
    logic              w_lat_zero;
    logic              w_limit;

    assign w_limit = (r_iter == ITER_LIM);

    lat_counter #(
        .W (LW)
    ) u_lat (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_lat_load),
        .i_en   (w_lat_en),
        .i_val  (LAT_INIT),
        .o_zero (w_lat_zero)
    );

    always_comb begin
        w_next     = r_state;
        w_lat_load = 1'b0;
        w_lat_en   = 1'b0;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) w_next = S_LOAD;
                end
                S_LOAD: w_next = S_CHECK;
                S_CHECK: begin
                    if (zer || w_limit) begin
                        w_next = S_DONE;
                    end else if (PU_LAT == 0) begin
                        w_next = S_UPDATE;
                    end else begin
                        w_next     = S_WAIT;
                        w_lat_load = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_lat_zero) w_next = S_UPDATE;
                    else            w_lat_en = 1'b1;
                end
                S_UPDATE: w_next = S_CHECK;
                S_DONE: begin
                    if (ack) w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // abort freezes the iteration count and timeout flag as they stood
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_iter    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (!abort) begin
                if (r_state == S_LOAD) begin
                    r_iter    <= '0;
                    r_timeout <= 1'b0;
                end
                if (r_state == S_UPDATE) begin
                    r_iter <= r_iter + 1'b1;
                end
                if (r_state == S_CHECK && !zer && w_limit) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign wen  = (r_state == S_LOAD) || (r_state == S_UPDATE);
    assign wene = (r_state == S_LOAD);
    assign sel  = (r_state == S_CHECK) || (r_state == S_WAIT) ||
                  (r_state == S_UPDATE) || (r_state == S_DONE);
    assign busy = (r_state == S_LOAD) || (r_state == S_CHECK) ||
                  (r_state == S_WAIT) || (r_state == S_UPDATE);
    assign done = (r_state == S_DONE);

    assign timeout    = r_timeout;
    assign iter_count = r_iter;

endmodule
